// File: rtl/ctest_nios_pio_in.sv
// Avalon-MM input port: synchroniser, optional debounce, edge capture
// with write-1-to-clear, and a maskable level interrupt.
module ctest_nios_pio_in #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned DEBOUNCE    = 0,
  parameter int unsigned EDGE_TYPE   = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam int unsigned CNT_W  = (DEBOUNCE > 0) ? $clog2(DEBOUNCE + 1) : 1;
  // prev trails filt by one cycle, so suppression spans one edge past the
  // SYNC_STAGES+1 fill cycles to keep a held-high input from looking like an edge
  localparam int unsigned ST_MAX = SYNC_STAGES + 2;
  localparam int unsigned ST_W   = $clog2(ST_MAX + 1);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] r_sync;
  logic [WIDTH-1:0]                  r_filt;
  logic [WIDTH-1:0]                  r_prev;
  logic [WIDTH-1:0]                  r_irqmask;
  logic [WIDTH-1:0]                  r_edge;
  logic [ST_W-1:0]                   r_start_cnt;

  logic [WIDTH-1:0] w_sync;
  logic [WIDTH-1:0] w_event;
  logic [WIDTH-1:0] w_clr;
  logic [31:0]      w_rd_mux;
  logic             w_guard;
  logic             w_wr;
  logic             w_unused;

  assign w_sync   = r_sync[SYNC_STAGES-1];
  assign w_guard  = (r_start_cnt < ST_W'(ST_MAX));
  assign w_wr     = chipselect & ~write_n;
  assign w_unused = ^writedata;

  // Metastability chain, one shift register per input bit
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_sync <= '0;
    else          r_sync <= {r_sync[SYNC_STAGES-2:0], in_port};
  end

  // Startup guard counter, saturates once the pipeline is primed
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)     r_start_cnt <= '0;
    else if (w_guard) r_start_cnt <= r_start_cnt + ST_W'(1);
  end

  generate
    if (DEBOUNCE == 0) begin : g_bypass
      // Filtered value simply follows the synchroniser output
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_filt <= '0;
        else          r_filt <= w_sync;
      end
    end else begin : g_debounce
      logic [WIDTH-1:0][CNT_W-1:0] r_db_cnt;

      // Per-bit stability counters; any agreeing cycle restarts the count
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          r_filt   <= '0;
          r_db_cnt <= '0;
        end else if (w_guard) begin
          r_filt   <= w_sync;
          r_db_cnt <= '0;
        end else begin
          for (int i = 0; i < WIDTH; i++) begin
            if (w_sync[i] != r_filt[i]) begin
              if (r_db_cnt[i] == CNT_W'(DEBOUNCE)) begin
                r_filt[i]   <= w_sync[i];
                r_db_cnt[i] <= '0;
              end else begin
                r_db_cnt[i] <= r_db_cnt[i] + CNT_W'(1);
              end
            end else begin
              r_db_cnt[i] <= '0;
            end
          end
        end
      end
    end
  endgenerate

  // One-cycle history of the filtered value for edge detection
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_prev <= '0;
    else          r_prev <= r_filt;
  end

  // Edge events selected by EDGE_TYPE, masked during startup
  always_comb begin
    w_event = '0;
    if (!w_guard) begin
      if (EDGE_TYPE == 0)      w_event = r_filt & ~r_prev;
      else if (EDGE_TYPE == 1) w_event = ~r_filt & r_prev;
      else                     w_event = r_filt ^ r_prev;
    end
  end

  assign w_clr = (w_wr && address == 2'd3) ? writedata[WIDTH-1:0] : '0;

  // Interrupt mask register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                     r_irqmask <= '0;
    else if (w_wr && address == 2'd2) r_irqmask <= writedata[WIDTH-1:0];
  end

  // Edge capture; a new event overrides a same-cycle clear
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_edge <= '0;
    else          r_edge <= (r_edge & ~w_clr) | w_event;
  end

  // Level interrupt from captured and enabled edges
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) irq <= 1'b0;
    else          irq <= |(r_edge & r_irqmask);
  end

  // Read mux, unused and reserved bits return zero
  always_comb begin
    w_rd_mux = '0;
    case (address)
      2'd0:    w_rd_mux = 32'(r_filt);
      2'd2:    w_rd_mux = 32'(r_irqmask);
      2'd3:    w_rd_mux = 32'(r_edge);
      default: w_rd_mux = '0;
    endcase
  end

  // Registered read data, refreshed every cycle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) readdata <= '0;
    else          readdata <= w_rd_mux;
  end

endmodule

// File: tb/tb_ctest_nios_pio_in.sv
// Bench for ctest_nios_pio_in: four parameterisations share one bus.
module tb_ctest_nios_pio_in;

  localparam int unsigned S = 2;

  logic        clk;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [7:0]  in0, in1;
  logic [31:0] in2;
  logic [0:0]  in3;
  logic [31:0] rd0, rd1, rd2, rd3;
  logic        irq0, irq1, irq2, irq3;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];

  ctest_nios_pio_in #(.WIDTH(8), .SYNC_STAGES(S), .DEBOUNCE(0), .EDGE_TYPE(0)) u0 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in0), .readdata(rd0), .irq(irq0));
  ctest_nios_pio_in #(.WIDTH(8), .SYNC_STAGES(S), .DEBOUNCE(4), .EDGE_TYPE(0)) u1 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in1), .readdata(rd1), .irq(irq1));
  ctest_nios_pio_in #(.WIDTH(32), .SYNC_STAGES(S), .DEBOUNCE(0), .EDGE_TYPE(2)) u2 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in2), .readdata(rd2), .irq(irq2));
  ctest_nios_pio_in #(.WIDTH(1), .SYNC_STAGES(S), .DEBOUNCE(0), .EDGE_TYPE(0)) u3 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in3), .readdata(rd3), .irq(irq3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    address = a; chipselect = 1'b1; write_n = 1'b0; writedata = d;
    tick(1);
    chipselect = 1'b0; write_n = 1'b1; writedata = '0;
  endtask

  task automatic test_reset();
    logic [31:0] e;
    reset_n = 1'b0; in0 = 8'hFF; in1 = '0; in2 = '0; in3 = 1'b1;
    tick(3);
    reset_n = 1'b1;
    tick(10);
    address = 2'd0; exp_q.push_back(32'hFF); exp_q.push_back(32'h1);
    tick(1);
    e = exp_q.pop_front(); total++;
    if (rd0 !== e) begin bad++; $display("FAIL reset_data0 got=%h exp=%h", rd0, e); end
    e = exp_q.pop_front(); total++;
    if (rd3 !== e) begin bad++; $display("FAIL reset_data3 got=%h exp=%h", rd3, e); end
    address = 2'd3; exp_q.push_back(32'h0); exp_q.push_back(32'h0);
    tick(1);
    e = exp_q.pop_front(); total++;
    if (rd0 !== e) begin bad++; $display("FAIL reset_edge0 got=%h exp=%h", rd0, e); end
    e = exp_q.pop_front(); total++;
    if (rd3 !== e) begin bad++; $display("FAIL reset_edge3 got=%h exp=%h", rd3, e); end
    total++;
    if (irq0 !== 1'b0) begin bad++; $display("FAIL reset_irq got=%b exp=0", irq0); end
  endtask

  task automatic test_rising();
    logic [31:0] e;
    bus_write(2'd2, 32'h01);
    in0 = 8'h00;
    address = 2'd3;
    tick(6);
    in0 = 8'h01;
    exp_q.push_back(32'h0); exp_q.push_back(32'h1);
    for (int k = 1; k <= S + 3; k++) begin
      tick(1);
      if (k == S + 2) begin
        e = exp_q.pop_front(); total++;
        if (rd0 !== e || irq0 !== e[0]) begin
          bad++; $display("FAIL rise_early rd=%h irq=%b exp=%h", rd0, irq0, e);
        end
      end
      if (k == S + 3) begin
        e = exp_q.pop_front(); total++;
        if (rd0 !== e || irq0 !== e[0]) begin
          bad++; $display("FAIL rise_set rd=%h irq=%b exp=%h", rd0, irq0, e);
        end
      end
    end
    exp_q.push_back(32'h1); exp_q.push_back(32'h0);
    bus_write(2'd3, 32'h01);
    e = exp_q.pop_front(); total++;
    if (irq0 !== e[0]) begin bad++; $display("FAIL clr_irq_hold got=%b exp=%b", irq0, e[0]); end
    tick(1);
    e = exp_q.pop_front(); total++;
    if (irq0 !== e[0] || rd0 !== e) begin
      bad++; $display("FAIL clr_irq_low irq=%b rd=%h exp=%h", irq0, rd0, e);
    end
  endtask

  task automatic test_mask();
    logic [31:0] e;
    in0 = 8'h09;
    exp_q.push_back(32'h08);
    tick(S + 4);
    e = exp_q.pop_front(); total++;
    if (rd0 !== e || irq0 !== 1'b0) begin
      bad++; $display("FAIL mask_capture rd=%h irq=%b exp=%h/0", rd0, irq0, e);
    end
    exp_q.push_back(32'h0); exp_q.push_back(32'h1);
    bus_write(2'd2, 32'h08);
    e = exp_q.pop_front(); total++;
    if (irq0 !== e[0]) begin bad++; $display("FAIL mask_irq_wait got=%b exp=%b", irq0, e[0]); end
    tick(1);
    e = exp_q.pop_front(); total++;
    if (irq0 !== e[0]) begin bad++; $display("FAIL mask_irq_rise got=%b exp=%b", irq0, e[0]); end
    exp_q.push_back(32'h0);
    bus_write(2'd3, 32'h08);
    tick(1);
    e = exp_q.pop_front(); total++;
    if (rd0 !== e || irq0 !== 1'b0) begin
      bad++; $display("FAIL mask_clear rd=%h irq=%b exp=%h/0", rd0, irq0, e);
    end
  endtask

  task automatic test_debounce();
    logic [31:0] e;
    logic seen;
    address = 2'd0;
    seen = 1'b0;
    in1 = 8'h02;
    exp_q.push_back(32'h0);
    tick(3);
    in1 = 8'h00;
    for (int k = 0; k < 12; k++) begin
      tick(1);
      if (rd1[1]) seen = 1'b1;
    end
    e = exp_q.pop_front(); total++;
    if (seen !== e[0]) begin bad++; $display("FAIL db_short_data got=%b exp=%b", seen, e[0]); end
    address = 2'd3;
    exp_q.push_back(32'h0);
    tick(1);
    e = exp_q.pop_front(); total++;
    if (rd1 !== e) begin bad++; $display("FAIL db_short_edge got=%h exp=%h", rd1, e); end

    address = 2'd0;
    in1 = 8'h02;
    exp_q.push_back(32'h0); exp_q.push_back(32'h2);
    for (int k = 1; k <= 12; k++) begin
      tick(1);
      if (k == 6) in1 = 8'h00;
      if (k == S + 5) begin
        e = exp_q.pop_front(); total++;
        if (rd1 !== e) begin bad++; $display("FAIL db_long_early got=%h exp=%h", rd1, e); end
      end
      if (k == S + 6) begin
        e = exp_q.pop_front(); total++;
        if (rd1 !== e) begin bad++; $display("FAIL db_long_high got=%h exp=%h", rd1, e); end
      end
    end
    tick(4);
    address = 2'd3;
    exp_q.push_back(32'h2);
    tick(1);
    e = exp_q.pop_front(); total++;
    if (rd1 !== e) begin bad++; $display("FAIL db_long_edge got=%h exp=%h", rd1, e); end
    bus_write(2'd3, 32'h02);
  endtask

  task automatic test_collision();
    logic [31:0] e;
    in0 = 8'h0B;
    exp_q.push_back(32'h02);
    tick(S + 1);
    bus_write(2'd3, 32'h02);
    tick(1);
    e = exp_q.pop_front(); total++;
    if (rd0 !== e) begin bad++; $display("FAIL collide_set_wins got=%h exp=%h", rd0, e); end
    exp_q.push_back(32'h0);
    bus_write(2'd3, 32'h02);
    tick(1);
    e = exp_q.pop_front(); total++;
    if (rd0 !== e) begin bad++; $display("FAIL collide_later_clear got=%h exp=%h", rd0, e); end
  endtask

  task automatic test_sweep32();
    logic [31:0] e;
    address = 2'd3;
    in2 = 32'h8000_0000;
    exp_q.push_back(32'h8000_0000);
    tick(S + 4);
    e = exp_q.pop_front(); total++;
    if (rd2 !== e) begin bad++; $display("FAIL w32_rise got=%h exp=%h", rd2, e); end
    exp_q.push_back(32'h0);
    bus_write(2'd3, 32'h8000_0000);
    tick(1);
    e = exp_q.pop_front(); total++;
    if (rd2 !== e) begin bad++; $display("FAIL w32_clr1 got=%h exp=%h", rd2, e); end
    in2 = 32'h0;
    exp_q.push_back(32'h8000_0000);
    tick(S + 4);
    e = exp_q.pop_front(); total++;
    if (rd2 !== e) begin bad++; $display("FAIL w32_fall got=%h exp=%h", rd2, e); end
    exp_q.push_back(32'h0);
    bus_write(2'd3, 32'h8000_0000);
    tick(1);
    e = exp_q.pop_front(); total++;
    if (rd2 !== e) begin bad++; $display("FAIL w32_clr2 got=%h exp=%h", rd2, e); end
  endtask

  task automatic test_width1();
    logic [31:0] e;
    exp_q.push_back(32'h1);
    bus_write(2'd2, 32'hFFFF_FFFF);
    tick(1);
    e = exp_q.pop_front(); total++;
    if (rd3 !== e) begin bad++; $display("FAIL w1_mask got=%h exp=%h", rd3, e); end
    exp_q.push_back(32'h0);
    bus_write(2'd1, 32'hFFFF_FFFF);
    tick(1);
    e = exp_q.pop_front(); total++;
    if (rd3 !== e) begin bad++; $display("FAIL w1_reserved got=%h exp=%h", rd3, e); end
    exp_q.push_back(32'h1);
    bus_write(2'd0, 32'h0);
    tick(1);
    e = exp_q.pop_front(); total++;
    if (rd3 !== e) begin bad++; $display("FAIL w1_data got=%h exp=%h", rd3, e); end
    address = 2'd3;
    in3 = 1'b0;
    tick(S + 4);
    in3 = 1'b1;
    exp_q.push_back(32'h1);
    tick(S + 4);
    e = exp_q.pop_front(); total++;
    if (rd3 !== e || irq3 !== 1'b1) begin
      bad++; $display("FAIL w1_edge rd=%h irq=%b exp=%h/1", rd3, irq3, e);
    end
    exp_q.push_back(32'h0);
    bus_write(2'd3, 32'hFFFF_FFFF);
    tick(1);
    e = exp_q.pop_front(); total++;
    if (rd3 !== e || irq3 !== 1'b0) begin
      bad++; $display("FAIL w1_clear rd=%h irq=%b exp=%h/0", rd3, irq3, e);
    end
  endtask

  task automatic test_async_reset();
    logic [31:0] e;
    address = 2'd3;
    in3 = 1'b0;
    tick(S + 4);
    in3 = 1'b1;
    tick(S + 4);
    exp_q.push_back(32'h0);
    reset_n = 1'b0;
    #2;
    e = exp_q.pop_front(); total++;
    if (rd3 !== e || irq3 !== 1'b0) begin
      bad++; $display("FAIL async_clear rd=%h irq=%b exp=%h/0", rd3, irq3, e);
    end
    tick(2);
    reset_n = 1'b1;
    tick(10);
    address = 2'd2;
    exp_q.push_back(32'h0);
    tick(1);
    e = exp_q.pop_front(); total++;
    if (rd0 !== e) begin bad++; $display("FAIL rerst_mask got=%h exp=%h", rd0, e); end
    address = 2'd0;
    exp_q.push_back(32'h0B);
    tick(1);
    e = exp_q.pop_front(); total++;
    if (rd0 !== e) begin bad++; $display("FAIL rerst_data got=%h exp=%h", rd0, e); end
    address = 2'd3;
    exp_q.push_back(32'h0);
    tick(1);
    e = exp_q.pop_front(); total++;
    if (rd0 !== e || irq0 !== 1'b0) begin
      bad++; $display("FAIL rerst_no_edge rd=%h irq=%b exp=%h/0", rd0, irq0, e);
    end
  endtask

  initial begin
    reset_n = 1'b0; address = '0; chipselect = 1'b0; write_n = 1'b1; writedata = '0;
    in0 = '0; in1 = '0; in2 = '0; in3 = '0;
    test_reset();
    test_rising();
    test_mask();
    test_debounce();
    test_collision();
    test_sweep32();
    test_width1();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
